uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, 50000, max clk cycles between bytes inside a frame (50 ms at 1 MHz).
REQ-002 SHALL have port clk  input  1  system clock, 1 MHz domain.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-006 SHALL have port chr_cmd  output  8  ASCII command letter of last good frame.
REQ-007 SHALL have port chr_val0  output  8  ASCII tens digit of last good frame.
REQ-008 SHALL have port chr_val1  output  8  ASCII units digit of last good frame.
REQ-009 SHALL have port val_bin  output  7  binary value 10*d0+d1 of last good frame.
REQ-010 SHALL have port rx_msg_done  output  1  one-cycle pulse, new frame latched.
REQ-011 SHALL have port rx_err  output  1  one-cycle pulse, frame aborted.
REQ-012 SHALL have port err_code  output  2  cause of last abort: 01 bad char, 10 timeout, 11 resync.

Function
REQ-013 Frame format SHALL be '$'(0x24), cmd, d0, d1, terminator; cmd in {'A','B','C','D'} (max temp, min temp, max hum, min hum); d0,d1 in '0'-'9'; terminator 0x0A or 0x0D.
REQ-014 FSM states SHALL be IDLE, GET_CMD, GET_D0, GET_D1, GET_END; a byte is consumed only in a cycle with rx_valid=1.
REQ-015 IDLE: '$' -> GET_CMD; any other byte ignored, no rx_err.
REQ-016 GET_CMD/GET_D0/GET_D1/GET_END: a byte in the allowed set SHALL advance to the next state and be held in shadow registers.
REQ-017 Byte not allowed in current non-IDLE state (and not '$') -> rx_err pulse, err_code=01, go IDLE, shadow data discarded.
REQ-018 '$' received in any non-IDLE state -> rx_err pulse, err_code=11, go GET_CMD (resync; new frame starts).
REQ-019 Valid terminator in GET_END -> chr_cmd/chr_val0/chr_val1/val_bin updated and rx_msg_done=1 in the cycle after the terminator strobe; FSM to IDLE.
REQ-020 val_bin SHALL equal (d0-0x30)*10 + (d1-0x30), range 0-99, computed on registered shadow digits; no saturation needed.
REQ-021 Outputs chr_*, val_bin SHALL hold between good frames; never change on an aborted frame.
REQ-022 Inter-byte counter SHALL reset to 0 on every accepted byte and count in non-IDLE states; at TIMEOUT_CYC-1 with no rx_valid -> rx_err pulse, err_code=10, go IDLE.
REQ-023 rx_valid in the same cycle the timeout expires SHALL take priority: byte is processed, no timeout.
REQ-024 rx_msg_done and rx_err SHALL never be high in the same cycle; each is high exactly one cycle per event.
REQ-025 err_code SHALL hold its value until the next abort; it is unaffected by good frames.
REQ-026 Back-to-back rx_valid on consecutive cycles SHALL be accepted without loss.

Reset
REQ-027 rst_n=0 at a clk edge SHALL force state IDLE, counter 0, chr_cmd=chr_val0=chr_val1=0x30 ('0'), val_bin=0, rx_msg_done=0, rx_err=0, err_code=00.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no rx_msg_done or rx_err pulse.

Verification
REQ-029 Bytes "$A25\n" with 2-cycle gaps -> one rx_msg_done pulse 1 cycle after '\n'; chr_cmd=0x41, chr_val0=0x32, chr_val1=0x35, val_bin=25.
REQ-030 "$C7x\r" -> rx_err pulse on 'x', err_code=01; outputs retain previous frame; then "$D09\r" -> val_bin=9, chr_cmd=0x44.
REQ-031 "$B3" then no bytes for TIMEOUT_CYC cycles -> single rx_err, err_code=10; next "$B40\n" accepted, val_bin=40.
REQ-032 "$A1$B99\n" -> rx_err with err_code=11 at the second '$', then rx_msg_done with chr_cmd=0x42, val_bin=99.
REQ-033 Noise "xyz" in IDLE -> no pulses; rst_n low for 1 cycle after "$A1" -> no pulses, outputs at reset values.
REQ-034 "$A00\n$D99\r" with rx_valid on every cycle -> two rx_msg_done pulses, final val_bin=99.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Parses "$<cmd><d0><d1><term>" frames from a UART byte stream and latches the last good frame.
// Bad characters, inter-byte timeouts and mid-frame '$' resyncs each abort the frame with a coded error pulse.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] chr_cmd,
    output logic [7:0] chr_val0,
    output logic [7:0] chr_val1,
    output logic [6:0] val_bin,
    output logic       rx_msg_done,
    output logic       rx_err,
    output logic [1:0] err_code
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] ERR_BAD_CHR = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_RESYNC  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_D0,
        GET_D1,
        GET_END
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0] r_sh_cmd;
    logic [7:0] r_sh_d0;
    logic [7:0] r_sh_d1;

    logic [7:0] r_chr_cmd;
    logic [7:0] r_chr_val0;
    logic [7:0] r_chr_val1;
    logic [6:0] r_val_bin;
    logic       r_msg_done;
    logic       r_err;
    logic [1:0] r_err_code;

    logic       w_is_dollar;
    logic       w_is_cmd;
    logic       w_is_digit;
    logic       w_is_term;
    logic       w_timeout;
    logic       w_done;
    logic       w_err;
    logic [1:0] w_err_code;
    logic       w_ld_cmd;
    logic       w_ld_d0;
    logic       w_ld_d1;
    logic [6:0] w_val_bin;

    assign w_is_dollar = (rx_data == 8'h24);
    assign w_is_cmd    = (rx_data >= 8'h41) && (rx_data <= 8'h44);
    assign w_is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_term   = (rx_data == 8'h0A) || (rx_data == 8'h0D);

    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_timeout = (r_state != IDLE) && !rx_valid &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // ASCII '0'..'9' carry the digit value in their low nibble.
    assign w_val_bin = 7'(r_sh_d0[3:0]) * 7'd10 + 7'(r_sh_d1[3:0]);

    // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_err_code  = 2'b00;
        w_ld_cmd    = 1'b0;
        w_ld_d0     = 1'b0;
        w_ld_d1     = 1'b0;
        if (rx_valid) begin
            if (r_state != IDLE && w_is_dollar) begin
                w_err       = 1'b1;
                w_err_code  = ERR_RESYNC;
                w_state_nxt = GET_CMD;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_is_dollar) w_state_nxt = GET_CMD;
                    end
                    GET_CMD: begin
                        w_ld_cmd    = w_is_cmd;
                        w_state_nxt = w_is_cmd ? GET_D0 : IDLE;
                    end
                    GET_D0: begin
                        w_ld_d0     = w_is_digit;
                        w_state_nxt = w_is_digit ? GET_D1 : IDLE;
                    end
                    GET_D1: begin
                        w_ld_d1     = w_is_digit;
                        w_state_nxt = w_is_digit ? GET_END : IDLE;
                    end
                    GET_END: begin
                        w_done      = w_is_term;
                        w_state_nxt = IDLE;
                    end
                    default: w_state_nxt = IDLE;
                endcase
                if (r_state != IDLE && w_state_nxt == IDLE && !w_done) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_BAD_CHR;
                end
            end
        end else if (w_timeout) begin
            w_err       = 1'b1;
            w_err_code  = ERR_TIMEOUT;
            w_state_nxt = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_chr_cmd  <= 8'h30;
            r_chr_val0 <= 8'h30;
            r_chr_val1 <= 8'h30;
            r_val_bin  <= '0;
            r_msg_done <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= (rx_valid || r_state == IDLE || w_timeout) ? '0 : r_cnt + CNT_W'(1);
            r_msg_done <= w_done;
            r_err      <= w_err;
            if (w_err) r_err_code <= w_err_code;
            if (w_done) begin
                r_chr_cmd  <= r_sh_cmd;
                r_chr_val0 <= r_sh_d0;
                r_chr_val1 <= r_sh_d1;
                r_val_bin  <= w_val_bin;
            end
        end
    end

    // NOTE: shadow bytes need no reset; they are always written before a terminator can publish them.
    always_ff @(posedge clk) begin
        if (w_ld_cmd) r_sh_cmd <= rx_data;
        if (w_ld_d0)  r_sh_d0  <= rx_data;
        if (w_ld_d1)  r_sh_d1  <= rx_data;
    end

    assign chr_cmd     = r_chr_cmd;
    assign chr_val0    = r_chr_val0;
    assign chr_val1    = r_chr_val1;
    assign val_bin     = r_val_bin;
    assign rx_msg_done = r_msg_done;
    assign rx_err      = r_err;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed-vector bench for uart_cmd_parser with a short timeout so expiry cases stay fast.
module tb_uart_cmd_parser;

    localparam int T = 20;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] chr_cmd;
    logic [7:0] chr_val0;
    logic [7:0] chr_val1;
    logic [6:0] val_bin;
    logic       rx_msg_done;
    logic       rx_err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;

    uart_cmd_parser #(.TIMEOUT_CYC(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .chr_cmd    (chr_cmd),
        .chr_val0   (chr_val0),
        .chr_val1   (chr_val1),
        .val_bin    (val_bin),
        .rx_msg_done(rx_msg_done),
        .rx_err     (rx_err),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters settle shortly after each edge, well before the negedge checks read them.
    always @(posedge clk) begin
        #2;
        if (rx_msg_done === 1'b1) n_done++;
        if (rx_err === 1'b1) n_err++;
        if (rx_msg_done === 1'b1 && rx_err === 1'b1) begin
            errors++;
            $display("FAIL pulse_overlap: rx_msg_done=%b rx_err=%b, required not both high", rx_msg_done, rx_err);
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    task automatic stream(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_data  = s[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (chr_cmd !== 8'h30) begin errors++; $display("FAIL reset_chr_cmd: got %h need 30", chr_cmd); end
        checks++; if (chr_val0 !== 8'h30) begin errors++; $display("FAIL reset_chr_val0: got %h need 30", chr_val0); end
        checks++; if (chr_val1 !== 8'h30) begin errors++; $display("FAIL reset_chr_val1: got %h need 30", chr_val1); end
        checks++; if (val_bin !== 7'd0) begin errors++; $display("FAIL reset_val_bin: got %0d need 0", val_bin); end
        checks++; if (rx_msg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", rx_msg_done); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b need 0", rx_err); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code: got %b need 00", err_code); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame;
        int d0 = n_done;
        int e0 = n_err;
        send_str("$A25\n", 2);
        checks++; if (rx_msg_done !== 1'b1) begin errors++; $display("FAIL good_done_pulse: got %b need 1", rx_msg_done); end
        checks++; if (chr_cmd !== 8'h41) begin errors++; $display("FAIL good_chr_cmd: got %h need 41", chr_cmd); end
        checks++; if (chr_val0 !== 8'h32) begin errors++; $display("FAIL good_chr_val0: got %h need 32", chr_val0); end
        checks++; if (chr_val1 !== 8'h35) begin errors++; $display("FAIL good_chr_val1: got %h need 35", chr_val1); end
        checks++; if (val_bin !== 7'd25) begin errors++; $display("FAIL good_val_bin: got %0d need 25", val_bin); end
        @(negedge clk);
        checks++; if (rx_msg_done !== 1'b0) begin errors++; $display("FAIL good_done_width: got %b need 0", rx_msg_done); end
        repeat (3) @(negedge clk);
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL good_done_count: got %0d need 1", n_done - d0); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL good_err_count: got %0d need 0", n_err - e0); end
    endtask

    task automatic test_bad_char;
        int d0 = n_done;
        int e0 = n_err;
        send_str("$C7x", 2);
        checks++; if (rx_err !== 1'b1) begin errors++; $display("FAIL bad_err_pulse: got %b need 1", rx_err); end
        checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL bad_err_code: got %b need 01", err_code); end
        checks++; if (chr_cmd !== 8'h41) begin errors++; $display("FAIL bad_hold_cmd: got %h need 41", chr_cmd); end
        checks++; if (val_bin !== 7'd25) begin errors++; $display("FAIL bad_hold_val: got %0d need 25", val_bin); end
        send(8'h0D, 2);
        repeat (3) @(negedge clk);
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL bad_err_count: got %0d need 1", n_err - e0); end
        checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL bad_done_count: got %0d need 0", n_done - d0); end
        send_str("$D09\r", 2);
        checks++; if (rx_msg_done !== 1'b1) begin errors++; $display("FAIL d09_done: got %b need 1", rx_msg_done); end
        checks++; if (chr_cmd !== 8'h44) begin errors++; $display("FAIL d09_chr_cmd: got %h need 44", chr_cmd); end
        checks++; if (chr_val1 !== 8'h39) begin errors++; $display("FAIL d09_chr_val1: got %h need 39", chr_val1); end
        checks++; if (val_bin !== 7'd9) begin errors++; $display("FAIL d09_val_bin: got %0d need 9", val_bin); end
        checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL d09_err_code_held: got %b need 01", err_code); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int e0 = n_err;
        send_str("$B3", 2);
        repeat (T - 1) @(negedge clk);
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b need 0", rx_err); end
        @(negedge clk);
        checks++; if (rx_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b need 1", rx_err); end
        checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL tmo_err_code: got %b need 10", err_code); end
        checks++; if (val_bin !== 7'd9) begin errors++; $display("FAIL tmo_hold_val: got %0d need 9", val_bin); end
        repeat (T + 5) @(negedge clk);
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL tmo_err_count: got %0d need 1", n_err - e0); end
        send_str("$B40\n", 2);
        checks++; if (rx_msg_done !== 1'b1) begin errors++; $display("FAIL b40_done: got %b need 1", rx_msg_done); end
        checks++; if (chr_cmd !== 8'h42) begin errors++; $display("FAIL b40_chr_cmd: got %h need 42", chr_cmd); end
        checks++; if (val_bin !== 7'd40) begin errors++; $display("FAIL b40_val_bin: got %0d need 40", val_bin); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout_edge;
        int e0 = n_err;
        send_str("$A", 2);
        repeat (T - 2) @(negedge clk);
        send(8'h31, 0);
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL edge_no_tmo: got %b need 0", rx_err); end
        send_str("2\n", 0);
        checks++; if (rx_msg_done !== 1'b1) begin errors++; $display("FAIL edge_done: got %b need 1", rx_msg_done); end
        checks++; if (val_bin !== 7'd12) begin errors++; $display("FAIL edge_val_bin: got %0d need 12", val_bin); end
        repeat (2) @(negedge clk);
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL edge_err_count: got %0d need 0", n_err - e0); end
    endtask

    task automatic test_resync;
        int d0 = n_done;
        int e0 = n_err;
        send_str("$A1$", 1);
        checks++; if (rx_err !== 1'b1) begin errors++; $display("FAIL resync_pulse: got %b need 1", rx_err); end
        checks++; if (err_code !== 2'b11) begin errors++; $display("FAIL resync_err_code: got %b need 11", err_code); end
        send_str("B99\n", 1);
        checks++; if (rx_msg_done !== 1'b1) begin errors++; $display("FAIL resync_done: got %b need 1", rx_msg_done); end
        checks++; if (chr_cmd !== 8'h42) begin errors++; $display("FAIL resync_chr_cmd: got %h need 42", chr_cmd); end
        checks++; if (val_bin !== 7'd99) begin errors++; $display("FAIL resync_val_bin: got %0d need 99", val_bin); end
        repeat (2) @(negedge clk);
        checks++; if (n_err - e0 !== 1 || n_done - d0 !== 1) begin
            errors++; $display("FAIL resync_counts: got err %0d done %0d need 1 1", n_err - e0, n_done - d0);
        end
    endtask

    task automatic test_noise_reset;
        int d0 = n_done;
        int e0 = n_err;
        send_str("xyz", 1);
        repeat (2) @(negedge clk);
        checks++; if (n_err - e0 !== 0 || n_done - d0 !== 0) begin
            errors++; $display("FAIL noise_pulses: got err %0d done %0d need 0 0", n_err - e0, n_done - d0);
        end
        send_str("$A1", 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (T + 5) @(negedge clk);
        checks++; if (n_err - e0 !== 0 || n_done - d0 !== 0) begin
            errors++; $display("FAIL rst_pulses: got err %0d done %0d need 0 0", n_err - e0, n_done - d0);
        end
        checks++; if (chr_cmd !== 8'h30) begin errors++; $display("FAIL rst_chr_cmd: got %h need 30", chr_cmd); end
        checks++; if (val_bin !== 7'd0) begin errors++; $display("FAIL rst_val_bin: got %0d need 0", val_bin); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL rst_err_code: got %b need 00", err_code); end
    endtask

    task automatic test_back_to_back;
        int d0 = n_done;
        int e0 = n_err;
        stream("$A00\n$D99\r");
        repeat (2) @(negedge clk);
        checks++; if (n_done - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d need 2", n_done - d0); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL b2b_err_count: got %0d need 0", n_err - e0); end
        checks++; if (val_bin !== 7'd99) begin errors++; $display("FAIL b2b_val_bin: got %0d need 99", val_bin); end
        checks++; if (chr_cmd !== 8'h44) begin errors++; $display("FAIL b2b_chr_cmd: got %h need 44", chr_cmd); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_char;
        test_timeout;
        test_timeout_edge;
        test_resync;
        test_noise_reset;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
